// File: rtl/nibble_ser_pkg.sv
// Shared types and constants for the operand nibble serializer and its skid buffer.
package nibble_ser_pkg;

    localparam int WORD_W           = 64;
    localparam int NIBBLE_W         = 4;
    localparam int NIBBLES_PER_WORD = 16;
    localparam int IDX_W            = $clog2(NIBBLES_PER_WORD);
    localparam int CREDIT_W         = 3;
    localparam int GAP_CNT_W        = 16;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } ser_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
    } operand_pair_t;

    function automatic logic [NIBBLE_W-1:0] top_nibble(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: NIBBLE_W];
    endfunction

endpackage

// File: rtl/operand_skid_buf.sv
// Two-entry operand-pair FIFO with a registered ready and a pop port driven by the
// serializer FSM.
module operand_skid_buf
    import nibble_ser_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push_valid,
    output logic          o_push_ready,
    input  operand_pair_t i_push_data,
    input  logic          i_pop,
    output operand_pair_t o_head,
    output logic          o_empty
);

    operand_pair_t r_mem [2];
    logic [1:0]    r_count;
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic          r_ready;

    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_count_nxt;

    // Ready is registered, so a push can never land on a full buffer.
    assign w_push = i_push_valid && r_ready;
    assign w_pop  = i_pop && (r_count != 2'd0);

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that leaves it unassigned infers a latch.
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // NOTE: payload storage has no reset; validity lives only in the count and pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    assign o_push_ready = r_ready;
    assign o_head       = r_mem[r_rd_ptr];
    assign o_empty      = (r_count == 2'd0);

endmodule

// File: rtl/operand_nibble_serializer.sv
// Buffers 64-bit operand pairs and streams them as credit-limited 16-nibble frames, MSB first.
// Optional statistics counters (frames_sent, stall_cycles) are built when NIBBLE_SER_STATS_EN is defined.
module operand_nibble_serializer
    import nibble_ser_pkg::*;
#(
    parameter int MAX_CREDITS = 4,
    parameter int MIN_GAP     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_a,
    input  logic [WORD_W-1:0]   in_b,
    output logic                start,
    output logic [NIBBLE_W-1:0] data_out1,
    output logic [NIBBLE_W-1:0] data_out2,
    input  logic                credit_ret,
    output logic [CREDIT_W-1:0] credits,
    output logic                busy,
    output logic                credit_err
`ifdef NIBBLE_SER_STATS_EN
    ,
    output logic [15:0]         frames_sent,
    output logic [15:0]         stall_cycles
`endif
);

    localparam logic [CREDIT_W-1:0]  CRED_MAX = CREDIT_W'(MAX_CREDITS);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(MIN_GAP - 1);

    ser_state_t          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [GAP_CNT_W-1:0] r_gap_cnt;
    logic [WORD_W-1:0]   r_sh_a;
    logic [WORD_W-1:0]   r_sh_b;
    logic                r_start;
    logic [NIBBLE_W-1:0] r_lane_a;
    logic [NIBBLE_W-1:0] r_lane_b;
    logic [CREDIT_W-1:0] r_credits;
    logic                r_credit_err;

    logic                w_buf_ready;
    logic                w_buf_empty;
    operand_pair_t       w_push_data;
    operand_pair_t       w_head;
    logic                w_launch_ok;
    logic                w_at_last;
    logic                w_launch;

    assign w_push_data = '{a: in_a, b: in_b};

    operand_skid_buf u_skid_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (in_valid),
        .o_push_ready (w_buf_ready),
        .i_push_data  (w_push_data),
        .i_pop        (w_launch),
        .o_head       (w_head),
        .o_empty      (w_buf_empty)
    );

    // A launch is only taken from IDLE or, with no gap, straight off the last nibble.
    assign w_launch_ok = !w_buf_empty && (r_credits != '0);
    assign w_at_last   = (r_state == SEND) && (r_idx == LAST_IDX);
    assign w_launch    = w_launch_ok && ((r_state == IDLE) || (w_at_last && (MIN_GAP == 0)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_start   <= 1'b0;
            r_lane_a  <= '0;
            r_lane_b  <= '0;
        end else begin
            r_start  <= 1'b0;
            r_lane_a <= '0;
            r_lane_b <= '0;
            if (w_launch) begin
                r_state  <= SEND;
                r_idx    <= '0;
                r_start  <= 1'b1;
                r_lane_a <= top_nibble(w_head.a);
                r_lane_b <= top_nibble(w_head.b);
                r_sh_a   <= w_head.a << NIBBLE_W;
                r_sh_b   <= w_head.b << NIBBLE_W;
            end else begin
                case (r_state)
                    SEND: begin
                        if (w_at_last) begin
                            // The exit cycle already shows one zero, so a gap of one needs no GAP state.
                            if (MIN_GAP >= 2) begin
                                r_state   <= GAP;
                                r_gap_cnt <= GAP_CNT_W'(1);
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_idx    <= r_idx + 1'b1;
                            r_lane_a <= top_nibble(r_sh_a);
                            r_lane_b <= top_nibble(r_sh_b);
                            r_sh_a   <= r_sh_a << NIBBLE_W;
                            r_sh_b   <= r_sh_b << NIBBLE_W;
                        end
                    end
                    GAP: begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_state <= IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credits    <= CRED_MAX;
            r_credit_err <= 1'b0;
        end else if (w_launch && !credit_ret) begin
            r_credits <= r_credits - 1'b1;
        end else if (credit_ret && !w_launch) begin
            if (r_credits == CRED_MAX) begin
                r_credit_err <= 1'b1;
            end else begin
                r_credits <= r_credits + 1'b1;
            end
        end
    end

`ifdef NIBBLE_SER_STATS_EN
    logic [15:0] r_frames_sent;
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frames_sent  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_launch) begin
                r_frames_sent <= r_frames_sent + 1'b1;
            end
            if (!w_buf_empty && (r_credits == '0) && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign frames_sent  = r_frames_sent;
    assign stall_cycles = r_stall_cycles;
`endif

    assign in_ready   = w_buf_ready;
    assign start      = r_start;
    assign data_out1  = r_lane_a;
    assign data_out2  = r_lane_b;
    assign credits    = r_credits;
    assign credit_err = r_credit_err;
    assign busy       = (r_state != IDLE) || !w_buf_empty;

endmodule
